// File: rtl/orion_fork_pkg.sv
// orion_fork_pkg: shared state type for the clocked orion fork
package orion_fork_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} fork_state_e;
endpackage

// File: rtl/orion_sync_bit.sv
// orion_sync_bit: N-flop single-bit synchroniser with sync reset, STAGES=0 is a wire
module orion_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  if (STAGES == 0) begin : g_wire
    logic w_unused;
    assign w_unused = clk ^ reset;
    assign o_q = i_d;
  end else begin : g_ff
    logic [STAGES-1:0] r_q;
    // shift the async input through the flop chain
    always_ff @(posedge clk) begin
      if (reset) r_q <= {STAGES{RST_VAL}};
      else begin
        r_q[0] <= i_d;
        for (int k = 1; k < STAGES; k++) r_q[k] <= r_q[k-1];
      end
    end
    assign o_q = r_q[STAGES-1];
  end
endmodule

// File: rtl/orion_fork_sync.sv
// orion_fork_sync: 2-phase bundled-data broadcast from one input to masked outputs
module orion_fork_sync
  import orion_fork_pkg::*;
#(
  parameter int   NUM_OUT     = 2,
  parameter int   DATA_W      = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic P_INIT      = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inA_req,
  output logic               inA_ack,
  input  logic [DATA_W-1:0]  inA_data,
  input  logic [NUM_OUT-1:0] out_mask,
  output logic [NUM_OUT-1:0] out_req,
  input  logic [NUM_OUT-1:0] out_ack,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy,
  output logic               protocol_err
);
  fork_state_e        r_state;
  logic               r_ack;
  logic [NUM_OUT-1:0] r_req;
  logic [NUM_OUT-1:0] r_mask;
  logic [NUM_OUT-1:0] r_ack_prev;
  logic [DATA_W-1:0]  r_data;
  logic               r_err;
  logic               w_req_s;
  logic [NUM_OUT-1:0] w_ack_s;
  logic [NUM_OUT-1:0] w_done;
  logic [NUM_OUT-1:0] w_edge;
  logic [NUM_OUT-1:0] w_bad;

  orion_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(P_INIT)) u_sync_req (
    .clk(clk), .reset(reset), .i_d(inA_req), .o_q(w_req_s)
  );

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_ack
    orion_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(P_INIT)) u_sync_ack (
      .clk(clk), .reset(reset), .i_d(out_ack[i]), .o_q(w_ack_s[i])
    );
  end

  // a channel is done once it is masked off or its ack phase has caught up with its req
  assign w_done = ~r_mask | ~(w_ack_s ^ r_req);
  assign w_edge = w_ack_s ^ r_ack_prev;
  // only a masked-on channel that was still pending may see an ack edge, and only in WAIT
  assign w_bad  = (r_state == WAIT) ? w_edge & (~r_mask | ~(r_ack_prev ^ r_req)) : w_edge;

  // capture, launch and completion sequencing plus sticky error tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ack      <= P_INIT;
      r_req      <= {NUM_OUT{P_INIT}};
      r_mask     <= '0;
      r_ack_prev <= {NUM_OUT{P_INIT}};
      r_data     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ack_prev <= w_ack_s;
      r_err      <= r_err | (|w_bad);
      case (r_state)
        IDLE: if (w_req_s != r_ack) begin
          r_data  <= inA_data;
          r_mask  <= out_mask;
          r_state <= LAUNCH;
        end
        LAUNCH: if (r_mask == '0) begin
          r_ack   <= ~r_ack;
          r_state <= IDLE;
        end else begin
          r_req   <= r_req ^ r_mask;
          r_state <= WAIT;
        end
        WAIT: if (&w_done) begin
          r_ack   <= ~r_ack;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inA_ack      = r_ack;
  assign out_req      = r_req;
  assign out_data     = r_data;
  assign busy         = r_state != IDLE;
  assign protocol_err = r_err;
endmodule

// File: tb/tb_orion_fork_sync.sv
// tb_orion_fork_sync: directed timing checks plus randomized token stream against a phase model
module tb_orion_fork_sync;
  localparam int S = 2;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         a_req = 1'b0, a_ack, a_busy, a_err;
  logic [7:0]   a_data = '0, a_odata;
  logic [N-1:0] a_mask = '0, a_oreq, a_oack = '0;
  logic         b_req = 1'b0, b_ack, b_busy, b_err;
  logic [7:0]   b_data = '0, b_odata;
  logic [N-1:0] b_mask = '0, b_oreq, b_oack = '0;

  orion_fork_sync #(.NUM_OUT(N), .DATA_W(8), .SYNC_STAGES(S), .P_INIT(1'b0)) u_dut_a (
    .clk(clk), .reset(reset), .inA_req(a_req), .inA_ack(a_ack), .inA_data(a_data),
    .out_mask(a_mask), .out_req(a_oreq), .out_ack(a_oack), .out_data(a_odata),
    .busy(a_busy), .protocol_err(a_err)
  );

  orion_fork_sync #(.NUM_OUT(N), .DATA_W(8), .SYNC_STAGES(0), .P_INIT(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .inA_req(b_req), .inA_ack(b_ack), .inA_data(b_data),
    .out_mask(b_mask), .out_req(b_oreq), .out_ack(b_oack), .out_data(b_odata),
    .busy(b_busy), .protocol_err(b_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] a_en = '0, a_exp = '0, b_en = '0, b_exp = '0;
  int a_dly[N], a_cnt[N], b_dly[N], b_cnt[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock; consumers answer each enabled pending request after their programmed delay
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (a_en[i] && a_oreq[i] !== a_oack[i]) begin
        if (a_cnt[i] >= a_dly[i]) begin a_oack[i] = ~a_oack[i]; a_cnt[i] = 0; end
        else a_cnt[i]++;
      end
      if (b_en[i] && b_oreq[i] !== b_oack[i]) begin
        if (b_cnt[i] >= b_dly[i]) begin b_oack[i] = ~b_oack[i]; b_cnt[i] = 0; end
        else b_cnt[i]++;
      end
    end
  endtask

  task automatic run_token(input logic [7:0] d, input logic [N-1:0] m, input int exp_lat,
                           input int inj_k, input logic [N-1:0] inj_m, input int stop_k);
    int lat;
    lat = 0;
    a_data = d;
    a_mask = m;
    a_en = m;
    for (int i = 0; i < N; i++) a_cnt[i] = 0;
    a_req = ~a_req;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      cycle();
      if (k == S + 1) begin
        check("a_capture_data", 32'(a_odata), 32'(d));
        check("a_req_held", 32'(a_oreq), 32'(a_exp));
        check("a_busy_run", 32'(a_busy), 32'd1);
        a_mask = ~m;
      end
      if (k == inj_k) a_oack = a_oack ^ inj_m;
      if (k == stop_k) return;
      if (a_ack == a_req) lat = k;
    end
    check("a_latency", 32'(lat), 32'(exp_lat));
    check("a_out_req", 32'(a_oreq), 32'(a_exp ^ m));
    check("a_out_data", 32'(a_odata), 32'(d));
    check("a_busy_idle", 32'(a_busy), 32'd0);
    a_exp = a_exp ^ m;
  endtask

  initial begin
    int lat, mx;
    logic [7:0] d;
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) begin a_dly[i] = 0; b_dly[i] = 0; a_cnt[i] = 0; b_cnt[i] = 0; end
    repeat (3) cycle();
    check("rst_ack", 32'(a_ack), 32'd0);
    check("rst_req", 32'(a_oreq), 32'd0);
    check("rst_data", 32'(a_odata), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    reset = 1'b0;

    run_token(8'hA5, 3'b011, 2*S+3, 0, '0, 0);
    check("t1_err", 32'(a_err), 32'd0);

    a_dly = '{0, 0, 10};
    run_token(8'h3C, 3'b101, 2*S+13, 0, '0, 0);
    check("t2_err", 32'(a_err), 32'd0);

    run_token(8'h5A, 3'b000, S+2, 0, '0, 0);
    check("t3_err", 32'(a_err), 32'd0);

    a_dly = '{6, 0, 0};
    run_token(8'hC3, 3'b001, 2*S+9, S+3, 3'b010, 0);
    check("t4_err_set", 32'(a_err), 32'd1);
    a_oack[1] = ~a_oack[1];
    repeat (4) cycle();
    check("t4_err_sticky", 32'(a_err), 32'd1);

    a_dly = '{20, 20, 20};
    run_token(8'h77, 3'b011, 0, 0, '0, S+4);
    reset = 1'b1;
    a_req = 1'b0;
    a_oack = '0;
    a_en = '0;
    cycle();
    check("t5_ack", 32'(a_ack), 32'd0);
    check("t5_req", 32'(a_oreq), 32'd0);
    check("t5_data", 32'(a_odata), 32'd0);
    check("t5_busy", 32'(a_busy), 32'd0);
    check("t5_err", 32'(a_err), 32'd0);
    reset = 1'b0;
    a_exp = '0;
    a_dly = '{0, 1, 2};
    run_token(8'hE1, 3'b111, 2*S+5, 0, '0, 0);
    check("t5_err_after", 32'(a_err), 32'd0);

    for (int t = 0; t < 100; t++) begin
      d = 8'($urandom);
      m = N'($urandom_range(0, 7));
      mx = 0;
      for (int i = 0; i < N; i++) begin
        b_dly[i] = int'($urandom_range(0, 7));
        b_cnt[i] = 0;
        if (m[i] && b_dly[i] > mx) mx = b_dly[i];
      end
      b_data = d;
      b_mask = m;
      b_en = m;
      b_req = ~b_req;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
        cycle();
        if (k == 1) b_mask = N'($urandom);
        if (b_ack == b_req) lat = k;
      end
      check("b_latency", 32'(lat), 32'((m == '0) ? 2 : 3 + mx));
      check("b_out_req", 32'(b_oreq), 32'(b_exp ^ m));
      check("b_out_data", 32'(b_odata), 32'(d));
      b_exp = b_exp ^ m;
    end
    check("b_phase_in", 32'(b_ack), 32'(b_req));
    check("b_phase_out", 32'(b_oack), 32'(b_oreq));
    check("b_err", 32'(b_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
